pipe_reg_chain: RTL and testbench
=================================

// Module: pipe_reg_chain
// PURPOSE
//  Parametrised elastic pipeline register: STAGES back-to-back WIDTH-bit registers with
//  per-stage valid bits, valid/ready handshake, synchronous flush and async reset.
//  Generalises the 1-bit async-reset D flip-flop into the standard inter-stage register for
//  the CPU datapath (fetch->decode->execute), with bubble collapsing and stall support.
// PARAMETERS
//  WIDTH    8   data bits per stage (>=1)
//  STAGES   2   number of register stages (>=1)
//  RST_VAL  0   value loaded into every data register on RST (WIDTH bits)
// PORTS
//  CLK        in   1       clock, rising edge
//  RST        in   1       reset, asynchronous, active-high
//  FLUSH      in   1       synchronous flush, active-high
//  IN_VALID   in   1       upstream data valid
//  IN_READY   out  1       chain can accept IN_DATA this cycle
//  IN_DATA    in   WIDTH   upstream data
//  OUT_VALID  out  1       last stage holds valid data
//  OUT_READY  in   1       downstream accepts OUT_DATA this cycle
//  OUT_DATA   out  WIDTH   last stage data register
//  OCC        out  $clog2(STAGES+1)  number of valid stages (only with PIPE_REG_OCC_EN)
// BEHAVIOUR
//  - Stage i (0..STAGES-1) holds v[i], d[i]. Stage 0 is fed from IN_*; the last stage drives OUT_*.
//  - Ready chain (combinational): r[STAGES-1] = !v[STAGES-1] | OUT_READY;
//    r[i] = !v[i] | r[i+1]; IN_READY = r[0] & !FLUSH.
//  - OUT_VALID = v[STAGES-1] & !FLUSH. OUT_DATA = d[STAGES-1], always driven.
//  - Transfer at input: IN_VALID & IN_READY. Transfer at output: OUT_VALID & OUT_READY.
//  - Rising CLK, FLUSH=0: if r[i], v[i] <= v[i-1] (v[-1] = IN_VALID) and d[i] <= d[i-1]
//    (d[-1] = IN_DATA), but d[i] updates only when the incoming valid is 1. Stage not ready: hold.
//  - Bubbles collapse: an empty stage accepts even while downstream is stalled.
//  - Latency: STAGES cycles from input transfer to OUT_VALID with OUT_READY held high.
//    Throughput: 1 word/cycle sustained.
//  - Full: all v=1 and OUT_READY=0 -> IN_READY=0; all state holds; no data lost or duplicated.
//  - Full with OUT_READY=1: simultaneous in/out transfer in the same cycle; occupancy unchanged.
//  - Empty: OUT_VALID=0; OUT_DATA holds the last value loaded (RST_VAL after reset).
//  - FLUSH=1 at an edge: all v <= 0 and d unchanged. No transfer occurs in that cycle:
//    IN_READY=0 and OUT_VALID=0. FLUSH overrides IN_VALID.
//  - RST (async, any time, including mid-transfer): immediately all v=0 and all d=RST_VAL.
//    Outputs: IN_READY=1, OUT_VALID=0, OUT_DATA=RST_VAL, OCC=0. Held while RST=1.
//  - Data order is strictly FIFO. No X on any output after reset.
// CONFIGURATION
//  - PIPE_REG_OCC_EN defined: OCC port present. It is a registered counter equal to the
//    popcount of v. Update rules:
//    - +1 on an input transfer alone; -1 on an output transfer alone;
//    - unchanged on both or neither;
//    - 0 on FLUSH or RST.
//    It never exceeds STAGES.
//  - PIPE_REG_OCC_EN undefined: no OCC port and no counter logic; all other behaviour identical.
// TESTING
//  1. RST pulse mid-stream (STAGES=2, 2 words held) -> same cycle: OUT_VALID=0,
//     OUT_DATA=RST_VAL(0x00), IN_READY=1, OCC=0.
//  2. OUT_READY=1; drive 0x11,0x22,0x33 on consecutive cycles -> OUT_VALID rises 2 cycles
//     after 0x11; outputs 0x11,0x22,0x33 on consecutive cycles.
//  3. OUT_READY=0; push 0xA1,0xA2 -> IN_READY=0 on the 3rd cycle, OCC=2. Then OUT_READY=1
//     with 0xA3 held -> 0xA1 out, 0xA3 accepted the same cycle, OCC stays 2.
//  4. Bubble: push 0x55 only, OUT_READY=0 -> 0x55 collapses to the last stage.
//     Then push 0x66 -> accepted; IN_READY=0 only after both are held.
//  5. FLUSH for 1 cycle with 2 words held and IN_VALID=1 (0x77) -> next cycle OUT_VALID=0,
//     OCC=0. 0x77 is not accepted; a new push after the flush is seen at output 2 cycles later.
//  6. STAGES=1, WIDTH=32: random IN_VALID/OUT_READY for 1000 cycles -> scoreboard matches
//     in-order with no loss or duplication; OCC equals the model's count every cycle.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: elastic STAGES-deep valid/ready register chain with flush and bubble collapsing.
// Define PIPE_REG_OCC_EN to add the registered occupancy counter on OCC.
module pipe_reg_chain #(
    parameter int               WIDTH   = 8,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_DATA
`ifdef PIPE_REG_OCC_EN
    ,
    output logic [$clog2(STAGES+1)-1:0] OCC
`endif
);
    logic [STAGES-1:0] v, r;
    logic [STAGES:0]   vx;
    logic [WIDTH-1:0]  d  [STAGES];
    logic [WIDTH-1:0]  dx [STAGES+1];

    assign vx    = {v, IN_VALID};
    assign dx[0] = IN_DATA;

    // A stage can take new data unless it and every stage after it are full and the sink stalls.
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        assign r[g]    = OUT_READY | ~&v[STAGES-1:g];
        assign dx[g+1] = d[g];
    end

    assign IN_READY  = r[0] & ~FLUSH;
    assign OUT_VALID = v[STAGES-1] & ~FLUSH;
    assign OUT_DATA  = d[STAGES-1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v <= '0;
            for (int i = 0; i < STAGES; i++) d[i] <= RST_VAL;
        end else if (FLUSH) begin
            v <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (r[i]) begin
                    v[i] <= vx[i];
                    if (vx[i]) d[i] <= dx[i];
                end
            end
        end
    end

`ifdef PIPE_REG_OCC_EN
    localparam int OW = $clog2(STAGES+1);
    logic in_xfer, out_xfer;

    assign in_xfer  = IN_VALID & IN_READY;
    assign out_xfer = OUT_VALID & OUT_READY;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) OCC <= '0;
        else if (FLUSH) OCC <= '0;
        else if (in_xfer != out_xfer) OCC <= in_xfer ? OCC + OW'(1) : OCC - OW'(1);
    end
`endif
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: directed checks on a 2x8 chain plus a scoreboarded random run on a 1x32 chain.
module tb_pipe_reg_chain;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [7:0]  in_data = '0, out_data;
    logic [1:0]  occ;
    logic        b_in_valid = 1'b0, b_out_ready = 1'b0, b_in_ready, b_out_valid;
    logic [31:0] b_in_data = '0, b_out_data;
    logic        b_occ;
    int          checks = 0, errors = 0;
    logic [31:0] q [$];
    logic [31:0] exp_d;

    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(8), .STAGES(2), .RST_VAL(8'h00)) dut_a (
        .CLK(clk), .RST(rst), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data)
`ifdef PIPE_REG_OCC_EN
        , .OCC(occ)
`endif
    );

    pipe_reg_chain #(.WIDTH(32), .STAGES(1), .RST_VAL(32'h0)) dut_b (
        .CLK(clk), .RST(rst), .FLUSH(1'b0),
        .IN_VALID(b_in_valid), .IN_READY(b_in_ready), .IN_DATA(b_in_data),
        .OUT_VALID(b_out_valid), .OUT_READY(b_out_ready), .OUT_DATA(b_out_data)
`ifdef PIPE_REG_OCC_EN
        , .OCC(b_occ)
`endif
    );

`ifndef PIPE_REG_OCC_EN
    assign occ   = '0;
    assign b_occ = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_occ(input string tag, input logic [31:0] exp);
`ifdef PIPE_REG_OCC_EN
        chk(tag, {30'd0, occ}, exp);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'h00);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk_occ("rst_occ", 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // streaming with the sink always ready
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
        #1 chk("s_in_ready", {31'd0, in_ready}, 32'd1);
        tick(); in_data = 8'h22;
        #1 chk("s_lat1_valid", {31'd0, out_valid}, 32'd0);
        tick(); in_data = 8'h33;
        #1 chk("s_out11_valid", {31'd0, out_valid}, 32'd1);
        chk("s_out11", {24'd0, out_data}, 32'h11);
        tick(); in_valid = 1'b0;
        #1 chk("s_out22", {24'd0, out_data}, 32'h22);
        tick();
        chk("s_out33_valid", {31'd0, out_valid}, 32'd1);
        chk("s_out33", {24'd0, out_data}, 32'h33);
        tick();
        chk("s_empty_valid", {31'd0, out_valid}, 32'd0);
        chk("s_empty_hold", {24'd0, out_data}, 32'h33);

        // fill with a stalled sink, then simultaneous in/out transfer
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA1;
        tick(); in_data = 8'hA2;
        tick(); in_data = 8'hA3;
        #1 chk("f_full_in_ready", {31'd0, in_ready}, 32'd0);
        chk_occ("f_full_occ", 32'd2);
        chk("f_full_out", {24'd0, out_data}, 32'hA1);
        tick();
        chk("f_hold_out", {24'd0, out_data}, 32'hA1);
        chk("f_hold_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1 chk("f_pass_in_ready", {31'd0, in_ready}, 32'd1);
        tick(); in_valid = 1'b0;
        #1 chk("f_pass_out", {24'd0, out_data}, 32'hA2);
        chk_occ("f_pass_occ", 32'd2);
        tick();
        chk("f_pass_a3", {24'd0, out_data}, 32'hA3);
        tick();
        chk("f_drain_valid", {31'd0, out_valid}, 32'd0);
        chk_occ("f_drain_occ", 32'd0);

        // bubble collapse
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h55;
        tick(); in_valid = 1'b0;
        tick();
        chk("b_collapse_valid", {31'd0, out_valid}, 32'd1);
        chk("b_collapse_data", {24'd0, out_data}, 32'h55);
        chk("b_in_ready", {31'd0, in_ready}, 32'd1);
        chk_occ("b_occ1", 32'd1);
        in_valid = 1'b1; in_data = 8'h66;
        tick(); in_valid = 1'b0;
        #1 chk("b_full_in_ready", {31'd0, in_ready}, 32'd0);
        chk_occ("b_occ2", 32'd2);

        // flush with two words held and a pending input
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
        #1 chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
        chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
        tick(); flush = 1'b0; in_valid = 1'b0;
        #1 chk("fl_after_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_after_data", {24'd0, out_data}, 32'h55);
        chk_occ("fl_after_occ", 32'd0);
        in_valid = 1'b1; in_data = 8'h88;
        tick(); in_valid = 1'b0;
        #1 chk("fl_new_lat1", {31'd0, out_valid}, 32'd0);
        tick();
        chk("fl_new_valid", {31'd0, out_valid}, 32'd1);
        chk("fl_new_data", {24'd0, out_data}, 32'h88);
        tick();

        // asynchronous reset mid-stream with two words held
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h99;
        tick(); in_data = 8'hAA;
        tick(); in_data = 8'hBB;
        #2 rst = 1'b1;
        #1 chk("r_out_valid", {31'd0, out_valid}, 32'd0);
        chk("r_out_data", {24'd0, out_data}, 32'h00);
        chk("r_in_ready", {31'd0, in_ready}, 32'd1);
        chk_occ("r_occ", 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("r_after_valid", {31'd0, out_valid}, 32'd0);

        // single-stage 32-bit chain against a queue model
        for (int n = 0; n < 1000; n++) begin
            b_in_valid  = 1'($urandom_range(0, 1));
            b_out_ready = 1'($urandom_range(0, 1));
            b_in_data   = $urandom;
            #1;
            chk("rnd_out_valid", {31'd0, b_out_valid}, {31'd0, q.size() > 0});
            chk("rnd_in_ready", {31'd0, b_in_ready}, {31'd0, q.size() == 0 || b_out_ready});
`ifdef PIPE_REG_OCC_EN
            chk("rnd_occ", {31'd0, b_occ}, q.size());
`endif
            if (q.size() > 0) begin
                exp_d = q[0];
                chk("rnd_out_data", b_out_data, exp_d);
                if (b_out_ready) void'(q.pop_front());
            end
            if (b_in_valid && (q.size() == 0)) q.push_back(b_in_data);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
